pulse_path_sched: RTL and testbench

- Cycle-based scheduler for one module path (in_sig => out_val) with rise/fall path delays.
- Applies reject/error pulse-limit filtering and showcancelled / on-event / on-detect X-reporting policy, including negative pulses caused by unequal rise/fall delays.
- Pulse-style configuration locks at first use; a later change is flagged as an error, not obeyed.
- Used as the reference model/controller behind specify-block pulse-control tests.

---
 rtl/pulse_path_sched.sv | 198 +++++++++++++++++++
 tb/tb_pulse_path_sched.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/pulse_path_sched.sv
// Single-path pulse scheduler: rise/fall delays, reject/error pulse limits and
// showcancelled / on-event / on-detect X-window policy. Pulse style locks at first edge.
module pulse_path_sched #(
  parameter int RISE_DLY   = 2,
  parameter int FALL_DLY   = 3,
  parameter int REJECT_LIM = 1,
  parameter int ERROR_LIM  = 4,
  parameter int CNT_W      = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_sig,
  input  logic             cfg_show_cancelled,
  input  logic             cfg_on_detect,
  output logic             out_val,
  output logic             out_x,
  output logic             pend,
  output logic             cfg_err,
  output logic [CNT_W-1:0] cancel_cnt,
  output logic [CNT_W-1:0] err_cnt
);
  localparam int MAXD0 = (RISE_DLY > FALL_DLY) ? RISE_DLY : FALL_DLY;
  localparam int MAXD  = (ERROR_LIM > MAXD0) ? ERROR_LIM : MAXD0;
  localparam int TW    = $clog2(MAXD + 2);
  localparam logic [TW-1:0] RISE_T = TW'(RISE_DLY);
  localparam logic [TW-1:0] FALL_T = TW'(FALL_DLY);
  localparam logic [TW-1:0] REJ_T  = TW'(REJECT_LIM);
  localparam logic [TW-1:0] ONE_T  = TW'(1);
  localparam logic [TW-1:0] TWO_T  = TW'(2);

  typedef enum logic [1:0] {IDLE = 2'd0, PEND = 2'd1, XWIN = 2'd2} state_t;

  state_t state_reg, state_next;
  logic in_q_reg, pv_reg, pv_next;
  logic out_val_reg, out_val_next, out_x_reg, out_x_next;
  logic locked_reg, locked_next, show_lat_reg, show_lat_next, det_lat_reg, det_lat_next;
  logic cfg_err_reg, cfg_err_next;
  // rem/xs/xe count cycles remaining to their target, measured from the last clock
  logic [TW-1:0] rem_reg, rem_next, age_reg, age_next;
  logic [TW-1:0] xs_reg, xs_next, xe_reg, xe_next;
  logic [CNT_W-1:0] cancel_reg, cancel_next, err_reg, err_next;
  logic edge_det, show_eff, det_eff, cancel_inc, err_inc;
  logic [TW-1:0] d_sel, w_cur, r_cur, s_off, e_off;

  always_comb begin
    state_next    = state_reg;
    pv_next       = pv_reg;
    rem_next      = rem_reg;
    age_next      = age_reg;
    xs_next       = xs_reg;
    xe_next       = xe_reg;
    out_val_next  = out_val_reg;
    out_x_next    = out_x_reg;
    locked_next   = locked_reg;
    show_lat_next = show_lat_reg;
    det_lat_next  = det_lat_reg;
    cancel_inc    = 1'b0;
    err_inc       = 1'b0;
    edge_det      = (in_sig != in_q_reg);
    d_sel         = in_sig ? RISE_T : FALL_T;
    show_eff      = locked_reg ? show_lat_reg : cfg_show_cancelled;
    det_eff       = locked_reg ? det_lat_reg : cfg_on_detect;
    w_cur         = age_reg + ONE_T;
    r_cur         = rem_reg - ONE_T;
    s_off         = ONE_T;
    e_off         = TWO_T;
    cfg_err_next  = cfg_err_reg | (locked_reg & ((cfg_show_cancelled != show_lat_reg) |
                                                 (cfg_on_detect != det_lat_reg)));
    if (edge_det && !locked_reg) begin
      locked_next   = 1'b1;
      show_lat_next = cfg_show_cancelled;
      det_lat_next  = cfg_on_detect;
    end

    // Anything due this cycle retires before the edge is considered
    case (state_reg)
      PEND: begin
        if (rem_reg == ONE_T) begin
          out_val_next = pv_reg;
          state_next   = IDLE;
        end else begin
          rem_next = r_cur;
          age_next = w_cur;
        end
      end
      XWIN: begin
        if (xs_reg == ONE_T) out_x_next = 1'b1;
        if (xs_reg != '0) xs_next = xs_reg - ONE_T;
        if (xe_reg == ONE_T) begin
          out_x_next   = 1'b0;
          out_val_next = pv_reg;
          xs_next      = '0;
          state_next   = IDLE;
        end else begin
          xe_next = xe_reg - ONE_T;
        end
      end
      default: ;
    endcase

    if (edge_det) begin
      case (state_next)
        IDLE: begin
          state_next = PEND;
          pv_next    = in_sig;
          rem_next   = d_sel;
          age_next   = '0;
        end
        PEND: begin
          if (w_cur < REJ_T) begin
            cancel_inc = 1'b1;
            state_next = IDLE;
          end else if ((d_sel <= r_cur) && !show_eff) begin
            cancel_inc = 1'b1;
            state_next = IDLE;
          end else begin
            err_inc    = 1'b1;
            state_next = XWIN;
            pv_next    = in_sig;
            if (d_sel <= r_cur) begin
              e_off = r_cur;
              s_off = det_eff ? ONE_T : d_sel;
            end else begin
              e_off = d_sel;
              s_off = det_eff ? ONE_T : r_cur;
            end
            // Keep at least one cycle of X between start and end
            if (e_off <= s_off) begin
              if (e_off > ONE_T) s_off = e_off - ONE_T;
              else begin
                s_off = ONE_T;
                e_off = TWO_T;
              end
            end
            xs_next = s_off;
            xe_next = e_off;
          end
        end
        XWIN: begin
          err_inc = 1'b1;
          pv_next = in_sig;
          xe_next = d_sel;
          if (!out_x_next) begin
            xs_next = ONE_T;
            if (d_sel < TWO_T) xe_next = TWO_T;
          end
        end
        default: ;
      endcase
    end
  end

  assign cancel_next = (cancel_inc && (cancel_reg != '1)) ? cancel_reg + 1'b1 : cancel_reg;
  assign err_next    = (err_inc && (err_reg != '1)) ? err_reg + 1'b1 : err_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      in_q_reg     <= 1'b0;
      pv_reg       <= 1'b0;
      rem_reg      <= '0;
      age_reg      <= '0;
      xs_reg       <= '0;
      xe_reg       <= '0;
      out_val_reg  <= 1'b0;
      out_x_reg    <= 1'b0;
      locked_reg   <= 1'b0;
      show_lat_reg <= 1'b0;
      det_lat_reg  <= 1'b0;
      cfg_err_reg  <= 1'b0;
      cancel_reg   <= '0;
      err_reg      <= '0;
    end else begin
      state_reg    <= state_next;
      in_q_reg     <= in_sig;
      pv_reg       <= pv_next;
      rem_reg      <= rem_next;
      age_reg      <= age_next;
      xs_reg       <= xs_next;
      xe_reg       <= xe_next;
      out_val_reg  <= out_val_next;
      out_x_reg    <= out_x_next;
      locked_reg   <= locked_next;
      show_lat_reg <= show_lat_next;
      det_lat_reg  <= det_lat_next;
      cfg_err_reg  <= cfg_err_next;
      cancel_reg   <= cancel_next;
      err_reg      <= err_next;
    end
  end

  assign out_val    = out_val_reg;
  assign out_x      = out_x_reg;
  assign pend       = (state_reg != IDLE);
  assign cfg_err    = cfg_err_reg;
  assign cancel_cnt = cancel_reg;
  assign err_cnt    = err_reg;
endmodule

// File: tb/tb_pulse_path_sched.sv
// Scoreboard bench: four scheduler instances with different delay/limit settings,
// expectations keyed by clock number and checked by an independent monitor.
module tb_pulse_path_sched;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic       rst_n [4];
  logic       in_sig[4];
  logic       show  [4];
  logic       det   [4];
  logic       o_val [4];
  logic       o_x   [4];
  logic       o_pend[4];
  logic       o_cerr[4];
  logic [7:0] o_cc  [4];
  logic [7:0] o_ec  [4];

  // 0: rise2 fall3 rej1 | 1: rise2 fall3 rej2 | 2: rise3 fall3 rej1 | 3: rise3 fall1 rej1
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_dut
      pulse_path_sched #(
        .RISE_DLY  ((gi >= 2) ? 3 : 2),
        .FALL_DLY  ((gi == 3) ? 1 : 3),
        .REJECT_LIM((gi == 1) ? 2 : 1),
        .ERROR_LIM (4),
        .CNT_W     (8)
      ) u_dut (
        .clk               (clk),
        .rst_n             (rst_n[gi]),
        .in_sig            (in_sig[gi]),
        .cfg_show_cancelled(show[gi]),
        .cfg_on_detect     (det[gi]),
        .out_val           (o_val[gi]),
        .out_x             (o_x[gi]),
        .pend              (o_pend[gi]),
        .cfg_err           (o_cerr[gi]),
        .cancel_cnt        (o_cc[gi]),
        .err_cnt           (o_ec[gi])
      );
    end
  endgenerate

  typedef struct {
    int         cyc;
    int         id;
    int         scen;
    int         k;
    logic       val;
    logic       x;
    logic       pd;
    logic       ce;
    logic [7:0] cc;
    logic [7:0] ec;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int failures = 0;

  task automatic push(int b, int k, int id, int sc, bit val, bit x, bit pd, bit ce, int cc, int ec);
    exp_t e;
    e.cyc = b + k; e.id = id; e.scen = sc; e.k = k;
    e.val = val; e.x = x; e.pd = pd; e.ce = ce;
    e.cc = 8'(cc); e.ec = 8'(ec);
    sb.push_back(e);
  endtask

  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      exp_t e;
      e = sb.pop_front();
      checks++;
      if ({o_val[e.id], o_x[e.id], o_pend[e.id], o_cerr[e.id], o_cc[e.id], o_ec[e.id]} !==
          {e.val, e.x, e.pd, e.ce, e.cc, e.ec}) begin
        failures++;
        $display("FAIL s%0d_k%0d dut%0d: got val=%b x=%b pend=%b cerr=%b cancel=%0d err=%0d, want val=%b x=%b pend=%b cerr=%b cancel=%0d err=%0d",
                 e.scen, e.k, e.id, o_val[e.id], o_x[e.id], o_pend[e.id], o_cerr[e.id],
                 o_cc[e.id], o_ec[e.id], e.val, e.x, e.pd, e.ce, e.cc, e.ec);
      end else begin
        $display("chk s%0d_k%0d dut%0d ok val=%b x=%b pend=%b cerr=%b cancel=%0d err=%0d",
                 e.scen, e.k, e.id, e.val, e.x, e.pd, e.ce, e.cc, e.ec);
      end
    end
  end

  // Return at the negedge just before clock c, so inputs set now are sampled at c
  task automatic go(int c);
    while (cyc < c - 1) @(negedge clk);
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      $display("FAIL drain: %0d expectations never reached", sb.size());
      $fatal(1, "scoreboard stalled");
    end
  endtask

  task automatic reset_dut(int id);
    @(negedge clk);
    rst_n[id] = 1'b0;
    @(negedge clk);
    rst_n[id] = 1'b1;
    @(negedge clk);
  endtask

  int b;

  initial begin
    for (int i = 0; i < 4; i++) begin
      rst_n[i] = 1'b0; in_sig[i] = 1'b0; show[i] = 1'b0; det[i] = 1'b0;
    end
    for (int i = 0; i < 4; i++) push(0, 2, i, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) push(0, 4, i, 0, 0, 0, 0, 0, 0, 0);
    go(4);
    for (int i = 0; i < 4; i++) rst_n[i] = 1'b1;
    drain();

    // s1: clean rise/fall with on_event, no filtering
    b = cyc + 2;
    for (int k = 9; k <= 25; k++)
      push(b, k, 0, 1, (k >= 12 && k < 23), 0, ((k >= 10 && k < 12) || (k >= 20 && k < 23)), 0, 0, 0);
    go(b + 10); in_sig[0] = 1'b1;
    go(b + 20); in_sig[0] = 1'b0;
    drain();

    // s2: 1-cycle pulse below REJECT_LIM=2 is silently dropped
    b = cyc + 2;
    for (int k = 9; k <= 14; k++)
      push(b, k, 1, 2, 0, 0, (k == 10), 0, (k >= 11) ? 1 : 0, 0);
    go(b + 10); in_sig[1] = 1'b1;
    go(b + 11); in_sig[1] = 1'b0;
    drain();

    // s3: pulse under ERROR_LIM, on_event then on_detect
    b = cyc + 2;
    for (int k = 9; k <= 16; k++)
      push(b, k, 2, 3, 0, (k == 13), (k >= 10 && k < 14), 0, 0, (k >= 11) ? 1 : 0);
    go(b + 10); in_sig[2] = 1'b1;
    go(b + 11); in_sig[2] = 1'b0;
    drain();
    reset_dut(2);
    det[2] = 1'b1;
    b = cyc + 2;
    for (int k = 9; k <= 16; k++)
      push(b, k, 2, 4, 0, (k == 12 || k == 13), (k >= 10 && k < 14), 0, 0, (k >= 11) ? 1 : 0);
    go(b + 10); in_sig[2] = 1'b1;
    go(b + 11); in_sig[2] = 1'b0;
    drain();

    // s5: negative pulse with noshowcancelled is cancelled
    b = cyc + 2;
    for (int k = 9; k <= 14; k++)
      push(b, k, 3, 5, 0, 0, (k == 10), 0, (k >= 11) ? 1 : 0, 0);
    go(b + 10); in_sig[3] = 1'b1;
    go(b + 11); in_sig[3] = 1'b0;
    drain();
    reset_dut(3);

    // s6: negative pulse with showcancelled + on_detect, then config change is flagged but ignored
    show[3] = 1'b1; det[3] = 1'b1;
    b = cyc + 2;
    for (int k = 9; k <= 25; k++)
      push(b, k, 3, 6, 0, (k == 12 || k == 22), ((k >= 10 && k < 13) || (k >= 20 && k < 23)),
           (k >= 15), 0, ((k >= 11) ? 1 : 0) + ((k >= 21) ? 1 : 0));
    go(b + 10); in_sig[3] = 1'b1;
    go(b + 11); in_sig[3] = 1'b0;
    go(b + 15); show[3] = 1'b0;
    go(b + 20); in_sig[3] = 1'b1;
    go(b + 21); in_sig[3] = 1'b0;
    drain();

    // s7: async reset mid-PEND clears everything and unlocks the config
    b = cyc + 2;
    for (int k = 9; k <= 19; k++) push(b, k, 0, 7, 0, 0, 0, 0, 0, 0);
    for (int k = 20; k <= 26; k++)
      push(b, k, 0, 7, 0, (k == 22 || k == 23), (k >= 20 && k < 24), 0, 0, (k >= 21) ? 1 : 0);
    go(b + 10); in_sig[0] = 1'b1;
    @(posedge clk);
    #2;
    rst_n[0] = 1'b0; in_sig[0] = 1'b0;
    go(b + 13);
    rst_n[0] = 1'b1; show[0] = 1'b1; det[0] = 1'b1;
    go(b + 20); in_sig[0] = 1'b1;
    go(b + 21); in_sig[0] = 1'b0;
    drain();

    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
